// File: rtl/axi4_slave_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi4_slave_mem
// Brief    : AXI4 slave backed by a word-addressed 32-bit RAM; FIXED/INCR/WRAP
//            bursts, byte strobes, ID reflection, independent read/write FSMs.
// Revision : 1.0
// ============================================================================
module axi4_slave_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic [ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic [ID_WIDTH-1:0]   S_AXI_BID,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic [ID_WIDTH-1:0]   S_AXI_RID,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] bytes;
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        bytes = ADDR_WIDTH'(1) << size;
        incr  = addr + bytes;
        // Container size for WRAP: (len+1)*bytes; low bits wrap inside it
        mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | (incr & mask);
            default: return incr;
        endcase
    endfunction

    function automatic logic f_attr_err(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    logic [31:0] r_mem [DEPTH_WORDS];

    // ---------------------------------------------------------------- write
    wstate_t               r_wstate, w_wstate_nxt;
    logic                  r_awready, r_wready, r_bvalid;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen, r_wcnt;
    logic [2:0]            r_wsize;
    logic [1:0]            r_wburst, r_bresp;
    logic [ID_WIDTH-1:0]   r_wid, r_bid;
    logic                  r_werr, r_wlast_err;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_w_last;

    assign w_aw_hs  = (r_wstate == W_IDLE) && r_awready && S_AXI_AWVALID;
    assign w_w_hs   = (r_wstate == W_DATA) && S_AXI_WVALID;
    assign w_b_hs   = (r_wstate == W_RESP) && S_AXI_BREADY;
    assign w_w_last = (r_wcnt == r_wlen);

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_w_last) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_waddr     <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wsize     <= '0;
            r_wburst    <= '0;
            r_wid       <= '0;
            r_werr      <= 1'b0;
            r_wlast_err <= 1'b0;
            r_bresp     <= '0;
            r_bid       <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_waddr     <= S_AXI_AWADDR;
                r_wlen      <= S_AXI_AWLEN;
                r_wsize     <= S_AXI_AWSIZE;
                r_wburst    <= S_AXI_AWBURST;
                r_wid       <= S_AXI_AWID;
                r_wcnt      <= '0;
                r_werr      <= f_attr_err(S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
                r_wlast_err <= 1'b0;
            end
            if (w_w_hs) begin
                r_waddr <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                r_wcnt  <= r_wcnt + 8'd1;
                if (S_AXI_WLAST != w_w_last) r_wlast_err <= 1'b1;
                if (w_w_last) begin
                    r_bresp <= (r_werr || r_wlast_err || (S_AXI_WLAST != w_w_last)) ? 2'b10 : 2'b00;
                    r_bid   <= r_wid;
                end
            end
        end
    end

    // RAM is deliberately not reset; errored bursts never write
    always_ff @(posedge clk) begin
        if (w_w_hs && !r_werr) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) r_mem[r_waddr[c_IDX_W+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BID     = r_bid;

    // ----------------------------------------------------------------- read
    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_arready, r_rvalid;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen, r_rcnt;
    logic [2:0]            r_rsize;
    logic [1:0]            r_rburst;
    logic [ID_WIDTH-1:0]   r_rid;
    logic                  r_rerr;
    logic                  w_ar_hs, w_r_hs, w_r_last;

    assign w_ar_hs  = (r_rstate == R_IDLE) && r_arready && S_AXI_ARVALID;
    assign w_r_hs   = (r_rstate == R_DATA) && S_AXI_RREADY;
    assign w_r_last = (r_rcnt == r_rlen);

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_r_last) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
            r_rid     <= '0;
            r_rerr    <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_raddr  <= S_AXI_ARADDR;
                r_rlen   <= S_AXI_ARLEN;
                r_rsize  <= S_AXI_ARSIZE;
                r_rburst <= S_AXI_ARBURST;
                r_rid    <= S_AXI_ARID;
                r_rcnt   <= '0;
                r_rerr   <= f_attr_err(S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
            end
            if (w_r_hs) begin
                r_raddr <= f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
                r_rcnt  <= r_rcnt + 8'd1;
            end
        end
    end

    // Combinational read sees pre-write data on a same-cycle collision
    assign S_AXI_RDATA   = (r_rvalid && !r_rerr) ? r_mem[r_raddr[c_IDX_W+1:2]] : 32'd0;
    assign S_AXI_RRESP   = (r_rvalid && r_rerr) ? 2'b10 : 2'b00;
    assign S_AXI_RLAST   = r_rvalid && w_r_last;
    assign S_AXI_RID     = r_rid;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_ARREADY = r_arready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi4_slave_mem
// Brief    : Directed self-checking bench for axi4_slave_mem.
// Revision : 1.0
// ============================================================================
module tb_axi4_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  awid, arid, bid, rid, wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    axi4_slave_mem #(.DEPTH_WORDS(1024), .ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWID(awid), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BID(bid), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARID(arid), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RID(rid), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] wdat [16];
    logic [31:0] edat [16];

    typedef struct {
        logic [31:0] waddr;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [3:0]  wid;
        logic [31:0] raddr;
        logic [3:0]  rid;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic aw_hs(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id);
        int g = 0;
        awaddr = a; awlen = l; awsize = s; awburst = b; awid = id; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && g < 50) begin g++; @(negedge clk); end
        chk("awready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic ar_hs(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id);
        int g = 0;
        araddr = a; arlen = l; arsize = s; arburst = b; arid = id; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && g < 50) begin g++; @(negedge clk); end
        chk("arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic [3:0] id, input logic [3:0] strb,
                             input int wlast_at, input logic [1:0] exp_resp);
        int g;
        aw_hs(a, l, s, b, id);
        for (int i = 0; i <= int'(l); i++) begin
            wdata = wdat[i]; wstrb = strb; wlast = (i == wlast_at); wvalid = 1'b1;
            g = 0;
            @(negedge clk);
            while (!wready && g < 50) begin g++; @(negedge clk); end
            if (!wready) chk("wready", 32'(wready), 32'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        @(negedge clk);
        chk("bvalid_after_last", 32'(bvalid), 32'd1);
        g = 0;
        while (!bvalid && g < 50) begin g++; @(negedge clk); end
        chk("bresp", 32'(bresp), 32'(exp_resp));
        chk("bid", 32'(bid), 32'(id));
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic [3:0] id, input bit toggle,
                            input logic [1:0] exp_resp);
        int beat = 0;
        int g    = 0;
        bit held = 1'b0;
        logic [31:0] hd = '0;
        logic hl = 1'b0;
        ar_hs(a, l, s, b, id);
        while (beat <= int'(l) && g < 200) begin
            rready = toggle ? g[0] : 1'b1;
            @(negedge clk);
            if (rvalid) begin
                if (held) begin
                    chk("rdata_stable", rdata, hd);
                    chk("rlast_stable", 32'(rlast), 32'(hl));
                end
                if (rready) begin
                    chk($sformatf("rdata[%0d]", beat), rdata, edat[beat]);
                    chk($sformatf("rresp[%0d]", beat), 32'(rresp), 32'(exp_resp));
                    chk($sformatf("rlast[%0d]", beat), 32'(rlast), 32'(beat == int'(l)));
                    chk($sformatf("rid[%0d]", beat), 32'(rid), 32'(id));
                    beat++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; hd = rdata; hl = rlast;
                end
            end
            g++;
            @(posedge clk); #1;
        end
        rready = 1'b0;
        chk("r_beats", 32'(beat), 32'(int'(l) + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h100,  3'd2, 4'hF, 32'hDEADBEEF, 4'd3,  32'h100, 4'd5,  32'hDEADBEEF};
        vt[1] = '{32'h040,  3'd2, 4'hF, 32'hFFFFFFFF, 4'd1,  32'h040, 4'd2,  32'hFFFFFFFF};
        vt[2] = '{32'h040,  3'd2, 4'h5, 32'h00000000, 4'd6,  32'h040, 4'd7,  32'hFF00FF00};
        vt[3] = '{32'h1040, 3'd2, 4'hA, 32'hCAFEF00D, 4'd9,  32'h040, 4'd10, 32'hCA00F000};
        vt[4] = '{32'h080,  3'd2, 4'hF, 32'h11223344, 4'd14, 32'h080, 4'd15, 32'h11223344};
        vt[5] = '{32'h081,  3'd0, 4'h2, 32'h0000AB00, 4'd0,  32'h080, 4'd1,  32'h1122AB44};

        rst_n = 1'b0;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awid = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arid = '0; arvalid = 1'b0;
        rready = 1'b0;
        #12;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_resp",    32'({bresp, rresp}), 32'd0);
        chk("rst_ids",     32'({bid, rid}), 32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        chk("rst_rlast",   32'(rlast), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("awready_before_edge", 32'(awready), 32'd0);
        @(posedge clk); #1;
        chk("awready_after_edge", 32'(awready), 32'd1);
        chk("arready_after_edge", 32'(arready), 32'd1);

        // Single-beat write/read table: strobes, aliasing, narrow writes
        for (int i = 0; i < 6; i++) begin
            wdat[0] = vt[i].data;
            axi_write(vt[i].waddr, 8'd0, vt[i].size, 2'b01, vt[i].wid, vt[i].strb, 0, 2'b00);
            edat[0] = vt[i].exp;
            axi_read(vt[i].raddr, 8'd0, 3'd2, 2'b01, vt[i].rid, 1'b0, 2'b00);
            chk("arready_after_rlast", 32'(arready), 32'd1);
        end

        // INCR burst with RREADY stalls
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); edat[i] = 32'(i + 1); end
        axi_write(32'h200, 8'd3, 3'd2, 2'b01, 4'd2, 4'hF, 3, 2'b00);
        axi_read(32'h200, 8'd3, 3'd2, 2'b01, 4'd8, 1'b1, 2'b00);

        // WRAP write from 0x308, read back linearly and as WRAP
        wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
        axi_write(32'h308, 8'd3, 3'd2, 2'b10, 4'd4, 4'hF, 3, 2'b00);
        edat[0] = 32'hC; edat[1] = 32'hD; edat[2] = 32'hA; edat[3] = 32'hB;
        axi_read(32'h300, 8'd3, 3'd2, 2'b01, 4'd4, 1'b0, 2'b00);
        edat[0] = 32'hA; edat[1] = 32'hB; edat[2] = 32'hC; edat[3] = 32'hD;
        axi_read(32'h308, 8'd3, 3'd2, 2'b10, 4'd4, 1'b0, 2'b00);

        // Concurrent write and read on different words
        wdat[0] = 32'h5555AAAA;
        edat[0] = 32'hDEADBEEF;
        fork
            axi_write(32'h44, 8'd0, 3'd2, 2'b01, 4'd11, 4'hF, 0, 2'b00);
            axi_read(32'h100, 8'd0, 3'd2, 2'b01, 4'd12, 1'b0, 2'b00);
        join
        edat[0] = 32'h5555AAAA;
        axi_read(32'h44, 8'd0, 3'd2, 2'b01, 4'd13, 1'b0, 2'b00);

        // Early WLAST: all beats still land, BRESP reports SLVERR
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        axi_write(32'h600, 8'd3, 3'd2, 2'b01, 4'd1, 4'hF, 1, 2'b10);
        for (int i = 0; i < 4; i++) edat[i] = wdat[i];
        axi_read(32'h600, 8'd3, 3'd2, 2'b01, 4'd1, 1'b0, 2'b00);

        // Oversized AWSIZE: SLVERR and no RAM update
        wdat[0] = 32'h12345678;
        axi_write(32'h500, 8'd0, 3'd2, 2'b01, 4'd2, 4'hF, 0, 2'b00);
        wdat[0] = 32'hAAAAAAAA;
        axi_write(32'h500, 8'd0, 3'd3, 2'b01, 4'd3, 4'hF, 0, 2'b10);
        edat[0] = 32'h12345678;
        axi_read(32'h500, 8'd0, 3'd2, 2'b01, 4'd3, 1'b0, 2'b00);

        // Reserved ARBURST and illegal WRAP length: zero data, SLVERR every beat
        for (int i = 0; i < 4; i++) edat[i] = 32'd0;
        axi_read(32'h100, 8'd1, 3'd2, 2'b11, 4'd6, 1'b0, 2'b10);
        axi_read(32'h200, 8'd2, 3'd2, 2'b10, 4'd7, 1'b0, 2'b10);

        // Asynchronous reset in the middle of a len=7 read
        ar_hs(32'h100, 8'd7, 3'd2, 2'b01, 4'd9);
        rready = 1'b1;
        @(negedge clk);
        chk("mid_rvalid_beat1", 32'(rvalid), 32'd1);
        chk("mid_rdata_beat1", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rvalid", 32'(rvalid), 32'd0);
        chk("async_arready", 32'(arready), 32'd0);
        chk("async_rlast", 32'(rlast), 32'd0);
        rready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arready_held_low", 32'(arready), 32'd0);
        @(posedge clk); #1;
        chk("arready_after_release", 32'(arready), 32'd1);
        edat[0] = 32'hDEADBEEF;
        axi_read(32'h100, 8'd0, 3'd2, 2'b01, 4'd5, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) edat[i] = 32'(i + 1);
        axi_read(32'h200, 8'd3, 3'd2, 2'b01, 4'd2, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
